// File: rtl/queue_serializer.sv
// -----------------------------------------------------------------------------
// queue_serializer
//
// Transmit-side drain of the 8-entry byte queue. While the queue reports a
// non-zero occupancy, one word is dequeued, loaded into a shift register and
// sent MSB first over a valid/ready serial handshake. Every frame passes
// through IDLE, DEQ and LOAD before its bit cycles, so back-to-back frames
// always have one IDLE cycle between them and the queue is never dequeued
// while empty.
//
// Every output is decoded from registered state only. No input reaches an
// output through combinational logic.
//
// Optional feature (compile-time macro QSER_PARITY_EN):
//   defined   : each frame carries DATA_W data bits followed by one even-parity
//               bit (XOR of the data bits). last_out flags the parity bit.
//   undefined : each frame carries DATA_W data bits. last_out flags the LSB.
//
// Parameters:
//   DATA_W  word width and number of data bits per frame
//   LEN_W   width of the queue occupancy count
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   asynchronous, active-high
//   len_in         in   queue occupancy (queue len_out)
//   data_in        in   dequeued word, valid in the cycle after deq_out
//   deq_out        out  one-cycle dequeue request (queue deq_in)
//   ser_data_out   out  current serial bit
//   ser_valid_out  out  ser_data_out holds a valid bit
//   ser_ready_in   in   downstream accepts the bit on this rising edge
//   last_out       out  high while the final bit of the frame is presented
//   busy_out       out  high in every state except IDLE
// -----------------------------------------------------------------------------
module queue_serializer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              deq_out,
    output logic              ser_data_out,
    output logic              ser_valid_out,
    input  logic              ser_ready_in,
    output logic              last_out,
    output logic              busy_out
);

`ifdef QSER_PARITY_EN
    localparam int FRAME = DATA_W + 1;
`else
    localparam int FRAME = DATA_W;
`endif
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEQ   = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [FRAME-1:0] shreg;
    logic [FRAME-1:0] load_word;
    logic [CNT_W-1:0] cnt;
    logic             is_last;
    logic             accept;

    // The shift register is FRAME bits wide so the parity bit, when present,
    // simply trails the LSB and falls out of the same MSB tap.
`ifdef QSER_PARITY_EN
    assign load_word = {data_in, ^data_in};
`else
    assign load_word = data_in;
`endif

    assign is_last = (cnt == CNT_W'(FRAME - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation that disagrees with the synthesized flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        deq_out       = 1'b0;
        ser_valid_out = 1'b0;
        ser_data_out  = 1'b0;
        last_out      = 1'b0;
        busy_out      = 1'b1;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                busy_out = 1'b0;
                // Occupancy is looked at only here, so an empty queue is never
                // dequeued and a new frame always starts from IDLE.
                if (len_in != '0) begin
                    state_next = DEQ;
                end
            end
            DEQ: begin
                deq_out    = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                // Outputs are pure functions of state/shreg/cnt, so they hold
                // by themselves while ready is low.
                ser_valid_out = 1'b1;
                ser_data_out  = shreg[FRAME-1];
                last_out      = is_last;
                accept        = ser_ready_in;
                if (accept && is_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (state == LOAD) begin
            shreg <= load_word;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= {shreg[FRAME-2:0], 1'b0};
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule
